// File: rtl/spi_midi_rx.sv
// spi_midi_rx: receives MIDI bytes over a two-wire SPI link (mode 0, MSB first),
// realigns on idle gaps, and parses channel voice messages with running status
// into single-cycle note-on/note-off events for the voice allocator.
module spi_midi_rx #(
  parameter logic [3:0] CHANNEL      = 4'd0,
  parameter int         OMNI         = 1,
  parameter int         IDLE_TIMEOUT = 1024
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_SPI_sclk,
  input  logic       i_SPI_mosi,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_note_valid,
  output logic       o_note_on,
  output logic [6:0] o_note,
  output logic [6:0] o_velocity,
  output logic [3:0] o_channel
);

  localparam int                IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_TIMEOUT[IDLE_W-1:0];

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_D1 = 2'd1;
  localparam logic [1:0] ST_WAIT_D2 = 2'd2;

  // Synchronizer stages; mosi gets the same depth so it stays aligned with sclk.
  logic sclk_p0, sclk_p1, sclk_p2;
  logic mosi_p0, mosi_p1;
  logic rise;

  logic [6:0]        shift;
  logic [2:0]        bit_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic [1:0] state;
  logic [7:0] status;
  logic [6:0] d1;

  // Saturating idle-count increment: holds at the timeout value.
  function automatic logic [IDLE_W-1:0] idle_sat_inc(input logic [IDLE_W-1:0] cnt);
    logic [IDLE_W-1:0] nxt;
    nxt = cnt;
    if (cnt != IDLE_MAX) nxt = cnt + {{(IDLE_W-1){1'b0}}, 1'b1};
    return nxt;
  endfunction

  // Program change and channel pressure carry a single data byte.
  function automatic logic one_data_byte(input logic [7:0] st);
    return (st[7:4] == 4'hC) || (st[7:4] == 4'hD);
  endfunction

  // Only note messages on an accepted channel produce events.
  function automatic logic note_accepted(input logic [7:0] st);
    logic is_note;
    logic chan_ok;
    is_note = (st[7:4] == 4'h8) || (st[7:4] == 4'h9);
    chan_ok = (OMNI != 0) || (st[3:0] == CHANNEL);
    return is_note && chan_ok;
  endfunction

  // A note-on with zero velocity is treated as note-off.
  function automatic logic note_is_on(input logic [7:0] st, input logic [6:0] vel);
    return (st[7:4] == 4'h9) && (vel != 7'd0);
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2: previous sclk for edge detection.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      sclk_p0 <= i_SPI_sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      mosi_p0 <= i_SPI_mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  assign rise = sclk_p1 & ~sclk_p2;

  // Deserializer with idle realignment; an edge always takes priority over the timeout.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shift        <= 7'd0;
      bit_cnt      <= 3'd0;
      idle_cnt     <= '0;
      o_byte       <= 8'd0;
      o_byte_valid <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      if (rise) begin
        shift    <= {shift[5:0], mosi_p1};
        bit_cnt  <= bit_cnt + 3'd1;
        idle_cnt <= '0;
        if (bit_cnt == 3'd7) begin
          o_byte       <= {shift, mosi_p1};
          o_byte_valid <= 1'b1;
        end
      end else if (idle_cnt == IDLE_MAX) begin
        shift   <= 7'd0;
        bit_cnt <= 3'd0;
      end else begin
        idle_cnt <= idle_sat_inc(idle_cnt);
      end
    end
  end

  // Message parser: consumes each registered byte the cycle its pulse is high.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      status       <= 8'd0;
      d1           <= 7'd0;
      o_note_valid <= 1'b0;
      o_note_on    <= 1'b0;
      o_note       <= 7'd0;
      o_velocity   <= 7'd0;
      o_channel    <= 4'd0;
    end else begin
      o_note_valid <= 1'b0;
      if (o_byte_valid) begin
        if (o_byte[7]) begin
          if (o_byte[7:3] == 5'b11111) begin
            // Real-time bytes pass through without disturbing the parser.
            state <= state;
          end else if (o_byte[7:4] == 4'hF) begin
            status <= 8'd0;
            state  <= ST_IDLE;
          end else begin
            status <= o_byte;
            state  <= ST_WAIT_D1;
          end
        end else begin
          case (state)
            ST_WAIT_D1: begin
              d1 <= o_byte[6:0];
              if (!one_data_byte(status)) state <= ST_WAIT_D2;
            end
            ST_WAIT_D2: begin
              state <= ST_WAIT_D1;
              if (note_accepted(status)) begin
                o_note_valid <= 1'b1;
                o_note       <= d1;
                o_channel    <= status[3:0];
                o_note_on    <= note_is_on(status, o_byte[6:0]);
                o_velocity   <= note_is_on(status, o_byte[6:0]) ? o_byte[6:0] : 7'd0;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_midi_rx.sv
// Directed testbench for spi_midi_rx: an omni instance and a channel-2 instance.
module tb_spi_midi_rx;

  localparam int TMO = 64;

  typedef struct packed {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
    logic [3:0] ch;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sclk_a = 1'b0, mosi_a = 1'b0, sclk_b = 1'b0, mosi_b = 1'b0;

  logic       a_bv, a_nv, a_on, b_bv, b_nv, b_on;
  logic [7:0] a_byte, b_byte;
  logic [6:0] a_note, a_vel, b_note, b_vel;
  logic [3:0] a_ch, b_ch;

  int tests = 0;
  int fails = 0;

  int a_bytes = 0, b_bytes = 0, lat_err = 0, width_err = 0;
  logic a_prev_bv = 1'b0, a_prev_nv = 1'b0, b_prev_bv = 1'b0;
  ev_t ev_a[$];
  ev_t ev_b[$];

  always #5 clk = ~clk;

  spi_midi_rx #(.CHANNEL(4'd0), .OMNI(1), .IDLE_TIMEOUT(TMO)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_SPI_sclk(sclk_a), .i_SPI_mosi(mosi_a),
    .o_byte_valid(a_bv), .o_byte(a_byte), .o_note_valid(a_nv), .o_note_on(a_on),
    .o_note(a_note), .o_velocity(a_vel), .o_channel(a_ch));

  spi_midi_rx #(.CHANNEL(4'd2), .OMNI(0), .IDLE_TIMEOUT(TMO)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_SPI_sclk(sclk_b), .i_SPI_mosi(mosi_b),
    .o_byte_valid(b_bv), .o_byte(b_byte), .o_note_valid(b_nv), .o_note_on(b_on),
    .o_note(b_note), .o_velocity(b_vel), .o_channel(b_ch));

  // Pulse and event recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (a_bv) a_bytes <= a_bytes + 1;
    if (b_bv) b_bytes <= b_bytes + 1;
    if (a_nv) ev_a.push_back({a_on, a_note, a_vel, a_ch});
    if (b_nv) ev_b.push_back({b_on, b_note, b_vel, b_ch});
    if ((a_nv && !a_prev_bv) || (b_nv && !b_prev_bv)) lat_err <= lat_err + 1;
    if ((a_bv && a_prev_bv) || (a_nv && a_prev_nv)) width_err <= width_err + 1;
    a_prev_bv <= a_bv;
    a_prev_nv <= a_nv;
    b_prev_bv <= b_bv;
  end

  task automatic send_bits(input bit sel, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel) begin mosi_b = b[7-i]; sclk_b = 1'b0; end
      else     begin mosi_a = b[7-i]; sclk_a = 1'b0; end
      repeat (4) @(negedge clk);
      if (sel) sclk_b = 1'b1; else sclk_a = 1'b1;
      repeat (4) @(negedge clk);
    end
    @(negedge clk);
    if (sel) sclk_b = 1'b0; else sclk_a = 1'b0;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    send_bits(sel, b, 8);
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({a_bv, a_byte, a_nv, a_on, a_note, a_vel, a_ch} !== 34'd0) begin
      fails++;
      $display("FAIL reset_a: outputs %h, expected 0", {a_bv, a_byte, a_nv, a_on, a_note, a_vel, a_ch});
    end
    tests++;
    if ({b_bv, b_byte, b_nv, b_on, b_note, b_vel, b_ch} !== 34'd0) begin
      fails++;
      $display("FAIL reset_b: outputs %h, expected 0", {b_bv, b_byte, b_nv, b_on, b_note, b_vel, b_ch});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_note_on();
    int bb, eb;
    bb = a_bytes; eb = ev_a.size();
    send_byte(0, 8'h90); send_byte(0, 8'h3C); send_byte(0, 8'h64);
    settle();
    tests++;
    if (a_bytes - bb !== 3) begin fails++; $display("FAIL note_on_bytes: got %0d expected 3", a_bytes - bb); end
    tests++;
    if (a_byte !== 8'h64) begin fails++; $display("FAIL note_on_held_byte: got %h expected 64", a_byte); end
    tests++;
    if (ev_a.size() - eb !== 1) begin fails++; $display("FAIL note_on_count: got %0d expected 1", ev_a.size() - eb); end
    tests++;
    if (ev_a[eb] !== {1'b1, 7'd60, 7'd100, 4'd0}) begin
      fails++; $display("FAIL note_on_event: got %h expected %h", ev_a[eb], {1'b1, 7'd60, 7'd100, 4'd0});
    end
    tests++;
    if ({a_on, a_note, a_vel, a_ch} !== {1'b1, 7'd60, 7'd100, 4'd0}) begin
      fails++; $display("FAIL note_on_hold: got %h", {a_on, a_note, a_vel, a_ch});
    end
  endtask

  task automatic test_running_status();
    int eb;
    eb = ev_a.size();
    send_byte(0, 8'h91); send_byte(0, 8'h40); send_byte(0, 8'h7F);
    send_byte(0, 8'h40); send_byte(0, 8'h00);
    settle();
    tests++;
    if (ev_a.size() - eb !== 2) begin fails++; $display("FAIL running_count: got %0d expected 2", ev_a.size() - eb); end
    tests++;
    if (ev_a[eb] !== {1'b1, 7'd64, 7'd127, 4'd1}) begin
      fails++; $display("FAIL running_ev0: got %h expected %h", ev_a[eb], {1'b1, 7'd64, 7'd127, 4'd1});
    end
    tests++;
    if (ev_a[eb+1] !== {1'b0, 7'd64, 7'd0, 4'd1}) begin
      fails++; $display("FAIL running_ev1: got %h expected %h", ev_a[eb+1], {1'b0, 7'd64, 7'd0, 4'd1});
    end
  endtask

  task automatic test_realtime();
    int bb, eb;
    bb = a_bytes; eb = ev_a.size();
    send_byte(0, 8'h80); send_byte(0, 8'h3C); send_byte(0, 8'hF8); send_byte(0, 8'h20);
    settle();
    tests++;
    if (a_bytes - bb !== 4) begin fails++; $display("FAIL realtime_bytes: got %0d expected 4", a_bytes - bb); end
    tests++;
    if (ev_a.size() - eb !== 1) begin fails++; $display("FAIL realtime_count: got %0d expected 1", ev_a.size() - eb); end
    tests++;
    if (ev_a[eb] !== {1'b0, 7'd60, 7'd0, 4'd0}) begin
      fails++; $display("FAIL realtime_event: got %h expected %h", ev_a[eb], {1'b0, 7'd60, 7'd0, 4'd0});
    end
  endtask

  task automatic test_one_data();
    int eb;
    eb = ev_a.size();
    send_byte(0, 8'hC0); send_byte(0, 8'h05); send_byte(0, 8'h06);
    settle();
    tests++;
    if (ev_a.size() - eb !== 0) begin fails++; $display("FAIL progchange_events: got %0d expected 0", ev_a.size() - eb); end
    tests++;
    if (a_byte !== 8'h06) begin fails++; $display("FAIL progchange_byte: got %h expected 06", a_byte); end
  endtask

  task automatic test_channel_filter();
    int eb;
    eb = ev_b.size();
    send_byte(1, 8'h93); send_byte(1, 8'h3C); send_byte(1, 8'h40);
    settle();
    tests++;
    if (ev_b.size() - eb !== 0) begin fails++; $display("FAIL chan3_rejected: got %0d expected 0", ev_b.size() - eb); end
    send_byte(1, 8'h92); send_byte(1, 8'h3C); send_byte(1, 8'h40);
    settle();
    tests++;
    if (ev_b.size() - eb !== 1) begin fails++; $display("FAIL chan2_count: got %0d expected 1", ev_b.size() - eb); end
    tests++;
    if (ev_b[eb] !== {1'b1, 7'd60, 7'd64, 4'd2}) begin
      fails++; $display("FAIL chan2_event: got %h expected %h", ev_b[eb], {1'b1, 7'd60, 7'd64, 4'd2});
    end
    send_byte(1, 8'hF0); send_byte(1, 8'h3C); send_byte(1, 8'h40);
    settle();
    tests++;
    if (ev_b.size() - eb !== 1) begin fails++; $display("FAIL sysex_data_dropped: got %0d expected 1", ev_b.size() - eb); end
    tests++;
    if (b_bytes !== 9) begin fails++; $display("FAIL chan_b_bytes: got %0d expected 9", b_bytes); end
  endtask

  task automatic test_idle_timeout();
    int bb, eb;
    bb = a_bytes; eb = ev_a.size();
    send_bits(0, 8'hFF, 5);
    repeat (TMO + 10) @(negedge clk);
    tests++;
    if (a_bytes - bb !== 0) begin fails++; $display("FAIL partial_no_pulse: got %0d expected 0", a_bytes - bb); end
    send_byte(0, 8'h90); send_byte(0, 8'h3C); send_byte(0, 8'h64);
    settle();
    tests++;
    if (a_bytes - bb !== 3) begin fails++; $display("FAIL realign_bytes: got %0d expected 3", a_bytes - bb); end
    tests++;
    if (ev_a.size() - eb !== 1) begin fails++; $display("FAIL realign_count: got %0d expected 1", ev_a.size() - eb); end
    tests++;
    if (ev_a[eb] !== {1'b1, 7'd60, 7'd100, 4'd0}) begin
      fails++; $display("FAIL realign_event: got %h expected %h", ev_a[eb], {1'b1, 7'd60, 7'd100, 4'd0});
    end
  endtask

  task automatic test_reset_mid_message();
    int bb, eb;
    send_byte(0, 8'h90); send_byte(0, 8'h3C);
    // start the next byte, then reset partway through it
    send_bits(0, 8'hFF, 3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({a_bv, a_byte, a_nv, a_on, a_note, a_vel, a_ch} !== 34'd0) begin
      fails++; $display("FAIL midreset_outputs: got %h expected 0", {a_bv, a_byte, a_nv, a_on, a_note, a_vel, a_ch});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bb = a_bytes; eb = ev_a.size();
    send_byte(0, 8'h45);
    settle();
    tests++;
    if (a_bytes - bb !== 1) begin fails++; $display("FAIL midreset_bytes: got %0d expected 1", a_bytes - bb); end
    tests++;
    if (a_byte !== 8'h45) begin fails++; $display("FAIL midreset_byte: got %h expected 45", a_byte); end
    tests++;
    if (ev_a.size() - eb !== 0) begin fails++; $display("FAIL midreset_no_event: got %0d expected 0", ev_a.size() - eb); end
  endtask

  task automatic test_back_to_back();
    int eb;
    eb = ev_a.size();
    send_byte(0, 8'h95); send_byte(0, 8'h30); send_byte(0, 8'h00);
    send_byte(0, 8'h3E); send_byte(0, 8'h50);
    settle();
    tests++;
    if (ev_a.size() - eb !== 2) begin fails++; $display("FAIL b2b_count: got %0d expected 2", ev_a.size() - eb); end
    tests++;
    if (ev_a[eb] !== {1'b0, 7'd48, 7'd0, 4'd5}) begin
      fails++; $display("FAIL b2b_vel0_off: got %h expected %h", ev_a[eb], {1'b0, 7'd48, 7'd0, 4'd5});
    end
    tests++;
    if (ev_a[eb+1] !== {1'b1, 7'd62, 7'd80, 4'd5}) begin
      fails++; $display("FAIL b2b_ev1: got %h expected %h", ev_a[eb+1], {1'b1, 7'd62, 7'd80, 4'd5});
    end
    tests++;
    if (lat_err !== 0) begin fails++; $display("FAIL note_latency: got %0d late events expected 0", lat_err); end
    tests++;
    if (width_err !== 0) begin fails++; $display("FAIL pulse_width: got %0d wide pulses expected 0", width_err); end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_one_data();
    test_channel_filter();
    test_idle_timeout();
    test_reset_mid_message();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_midi_rx.md
# spi_midi_rx

Front-end stage between the SPI pins and the synthesis core. It deserializes MIDI bytes shifted in on the two-wire SPI link (sclk, mosi; no chip select) and parses them, including running status, into single-cycle note-on/note-off events for the voice allocator. It also exposes the last received byte for LED/debug display.

## Interface
Parameters:
- CHANNEL, 4'd0: MIDI channel accepted when OMNI = 0.
- OMNI, 1: 1 = accept note messages on all 16 channels.
- IDLE_TIMEOUT, 1024: i_clk cycles without an sclk rising edge after which the bit counter is cleared (byte realignment).

Ports:
- i_clk  in  1  system clock (PLL output); one clock domain.
- i_reset  in  1  asynchronous, active-high reset.
- i_SPI_sclk  in  1  SPI clock, asynchronous to i_clk.
- i_SPI_mosi  in  1  SPI data, MSB first.
- o_byte_valid  out  1  one-cycle pulse per received byte.
- o_byte  out  8  last received byte; held between pulses.
- o_note_valid  out  1  one-cycle pulse per accepted note event.
- o_note_on  out  1  1 = note on, 0 = note off.
- o_note  out  7  note number.
- o_velocity  out  7  velocity (0 for note off).
- o_channel  out  4  channel of the event.

## Operation
- SPI mode 0: mosi sampled on sclk rising edge. sclk and mosi each pass through 2 synchronizer flops; mosi is delayed identically so it stays aligned with sclk. Rising edge = synchronized sclk 1 now, 0 last cycle.
- On each rising edge: shift register <= {shift[6:0], mosi_sync}; 3-bit bit counter increments. On the edge that brings the counter from 7 to 0, the completed byte is registered to o_byte and o_byte_valid pulses.
- Idle counter: cleared on every rising edge, otherwise increments, saturating at IDLE_TIMEOUT. On reaching IDLE_TIMEOUT the bit counter and shift register clear; a partial byte is discarded without a pulse.
- Parser states: IDLE (no running status), WAIT_D1, WAIT_D2. Registers: status[7:0], d1[6:0].
- Byte 0xF8-0xFF (real-time): ignored completely; state, status and d1 unchanged, including between data bytes.
- Byte 0xF0-0xF7: status cleared, go to IDLE; following data bytes are discarded until the next channel status byte.
- Byte 0x80-0xEF: status <= byte, go to WAIT_D1 (aborts any message in progress).
- Data byte (bit7 = 0) in IDLE: discarded. In WAIT_D1: d1 <= byte; if status high nibble is 0xC or 0xD (one data byte), stay in WAIT_D1 with no event; otherwise go to WAIT_D2. In WAIT_D2: message complete; go to WAIT_D1 (running status retained).
- A completed message emits an event only if the status nibble is 0x8 or 0x9 and (OMNI or status[3:0] == CHANNEL). Then o_note = d1, o_channel = status[3:0]. For 0x9n with velocity > 0: o_note_on = 1, o_velocity = velocity. For 0x9n with velocity 0, or any 0x8n: o_note_on = 0, o_velocity = 0. Other statuses (Ax, Bx, Ex) complete silently.

## Timing
- Reset: every output is 0. Synchronizers, shift register, bit counter and idle counter are 0. Status is 0 and the parser is in IDLE.
- Input requirement: sclk high and low phases are each at least 3 i_clk periods; mosi is stable at least 3 i_clk periods around the sclk rising edge.
- Latency: the synchronized edge is detected 2-3 i_clk cycles after the sclk pin rises. o_byte_valid is asserted the cycle after the 8th edge is detected. o_note_valid is asserted the cycle after o_byte_valid of the completing byte.
- Event outputs (note_on, note, velocity, channel) update in the same cycle as o_note_valid and hold until the next event.
- Both pulses are exactly 1 cycle wide. Back-to-back bytes yield separate pulses.
- Asserting i_reset mid-byte or mid-message discards everything immediately. After release, reception restarts at bit 0 in IDLE.
- Idle timeout and a rising edge in the same cycle: the edge wins, so the bit is shifted and the idle counter clears.

## Test plan
- Bytes 0x90, 0x3C, 0x64 -> o_byte_valid pulses 3 times. o_note_valid pulses once, 1 cycle after the third byte pulse, with note_on=1, note=60, velocity=100, channel=0.
- Running status: 0x91, 0x40, 0x7F, 0x40, 0x00 -> two events: (on, 64, 127, ch1) then (off, 64, 0, ch1).
- 0x80, 0x3C, 0xF8 (real-time), 0x20 -> a single note-off event (note 60, velocity 0). 0xC0, 0x05, 0x06 -> no events, and the parser stays in WAIT_D1.
- OMNI=0, CHANNEL=2: 0x93 0x3C 0x40 -> no event; then 0x92 0x3C 0x40 -> event on ch2. 0xF0 0x3C 0x40 -> no event.
- Sequence 1: 5 sclk bits, then IDLE_TIMEOUT idle cycles, then 0x90 0x3C 0x64 -> no byte pulse for the partial bits; the following bytes are aligned and produce the correct event.
- Sequence 2: i_reset pulsed after 0x90 0x3C -> all outputs 0. A following 0x45 produces a byte pulse but no event.
